// File: rtl/cache_pkg.sv
// Shared types for the L3 refill path: controller state encoding, write-buffer
// entry layout and default sizing.
package cache_pkg;

  localparam int unsigned DEF_WBUF_DEPTH   = 4;
  localparam int unsigned CACHE_ADDR_WIDTH = 32;
  localparam int unsigned CACHE_DATA_WIDTH = 32;
  localparam int unsigned WADDR_WIDTH      = CACHE_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RESP
  } refill_state_e;

  // Stores are tracked by word address; byte offset lives in the enables.
  typedef struct packed {
    logic [WADDR_WIDTH-1:0]      waddr;
    logic [CACHE_DATA_WIDTH-1:0] data;
    logic [3:0]                  be;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Write-through store buffer: circular FIFO with a per-entry word-address
// comparator used by the refill controller for read-after-write ordering.
module wbuf_fifo
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wbuf_entry_t            entry_i,
  input  logic                   pop_i,
  input  logic [WADDR_WIDTH-1:0] match_addr_i,
  output wbuf_entry_t            head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       match_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wbuf_entry_t      mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A full buffer still accepts a store in the cycle its head is popped.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_q[i] && (mem_q[i].waddr == match_addr_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        mem_q[wr_ptr_q]   <= entry_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/l3_refill_ctrl.sv
// L3 miss refill controller: posts write-through stores from a small buffer,
// drains matching stores before a refill read, and returns the read word.
module l3_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int unsigned WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_miss_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [3:0]            byte_en_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  stall_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam int unsigned AW_W = ADDR_WIDTH - 2;

  refill_state_e         state_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [3:0]            bus_be_q;
  logic                  mem_valid_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  wbuf_entry_t            push_entry;
  wbuf_entry_t            head;
  logic [WADDR_WIDTH-1:0] miss_waddr;
  logic [WBUF_DEPTH-1:0]  match_vec;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   hit;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];
  assign miss_waddr      = WADDR_WIDTH'(addr_i[ADDR_WIDTH-1:2]);
  assign push_entry      = '{waddr: miss_waddr,
                             data:  CACHE_DATA_WIDTH'(wr_data_i),
                             be:    byte_en_i};

  assign pop     = bus_req_q && bus_we_q && bus_gnt_i;
  assign push    = wr_en_i && (!full || pop);
  assign stall_o = wr_en_i && full && !pop;
  // A store pushed this cycle counts as buffered for the RAW check.
  assign hit     = (|match_vec) || (push && (push_entry.waddr == miss_waddr));

  wbuf_fifo #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .entry_i     (push_entry),
    .pop_i       (pop),
    .match_addr_i(miss_waddr),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .match_o     (match_vec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      mem_valid_q <= 1'b0;
      mem_data_q  <= '0;
      unique case (state_q)
        ST_IDLE, ST_DRAIN: begin
          // Decisions wait for any posted write to be granted first, so the
          // buffer contents seen by the match logic are never mid-pop.
          if (bus_req_q) begin
            if (bus_gnt_i) begin
              bus_req_q   <= 1'b0;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= '0;
              bus_wdata_q <= '0;
              bus_be_q    <= '0;
            end
          end else if (rd_miss_i && !hit) begin
            state_q     <= ST_RD_REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
          end else begin
            state_q <= rd_miss_i ? ST_DRAIN : ST_IDLE;
            if (!empty) begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= 1'b1;
              bus_addr_q  <= {AW_W'(head.waddr), 2'b00};
              bus_wdata_q <= DATA_WIDTH'(head.data);
              bus_be_q    <= head.be;
            end
          end
        end
        ST_RD_REQ: begin
          if (bus_gnt_i) begin
            state_q    <= ST_RD_WAIT;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
          end
        end
        ST_RD_WAIT: begin
          if (bus_rvalid_i) begin
            state_q     <= ST_RESP;
            mem_valid_q <= 1'b1;
            mem_data_q  <= bus_rdata_i;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_data_o  = mem_data_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;

endmodule
